// File: rtl/kiwi_abend_pkg.sv
// Shared types and syndrome constants for the Kiwi abend-syndrome arbiter.
package kiwi_abend_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} abend_state_t;

  localparam logic [7:0] ABEND_IDLE         = 8'h00;
  localparam logic [7:0] ABEND_RUNNING      = 8'h80;
  localparam logic [7:0] ABEND_WDOG_DEFAULT = 8'hFE;

  // 0x00 and 0x80 are heartbeats; every other code ends the run.
  function automatic logic is_terminal(input logic [7:0] code);
    return (code != ABEND_IDLE) && (code != ABEND_RUNNING);
  endfunction

endpackage

// File: rtl/kiwi_rr_arbiter.sv
// N-way round-robin pick: first asserted request at or after i_ptr, wrapping.
// Purely combinational; o_vld low and o_grant zero when nothing is requesting.
module kiwi_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_slot;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_vld   = 1'b0;
    w_sum   = '0;
    w_slot  = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_slot = w_sum[IW-1:0];
      if (!o_vld && i_req[w_slot]) begin
        o_vld           = 1'b1;
        o_grant[w_slot] = 1'b1;
        o_idx           = w_slot;
      end
    end
  end

endmodule

// File: rtl/kiwi_abend_arbiter.sv
// Round-robin arbiter for the shared abend syndrome channel, latching the first terminal code.
// req_ready is combinational from req_valid/pointer/state; all other outputs registered.
module kiwi_abend_arbiter
  import kiwi_abend_pkg::*;
#(
  parameter int          N_THREADS  = 4,
  parameter int unsigned WDOG_LIMIT = 1000000,
  parameter logic [7:0]  WDOG_CODE  = ABEND_WDOG_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_THREADS-1:0]             req_valid,
  input  logic [8*N_THREADS-1:0]           req_code,
  output logic [N_THREADS-1:0]             req_ready,
  output logic [7:0]                       ksubsAbendSyndrome,
  output logic                             finished,
  output logic [$clog2(N_THREADS+1)-1:0]   winner_id,
  output logic [31:0]                      cycle_count
);

  localparam int IW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
  localparam int WW = $clog2(N_THREADS + 1);

  if (WDOG_CODE == ABEND_IDLE || WDOG_CODE == ABEND_RUNNING) begin : g_bad_wdog_code
    $error("kiwi_abend_arbiter: WDOG_CODE must be a terminal syndrome");
  end

  abend_state_t        r_state;
  logic [IW-1:0]       r_ptr;
  logic [31:0]         r_wdog;
  logic [7:0]          r_syn;
  logic [WW-1:0]       r_win;
  logic [31:0]         r_cnt;
  logic                r_fin;

  logic [N_THREADS-1:0] w_grant;
  logic [IW-1:0]        w_idx;
  logic                 w_vld;
  logic [7:0]           w_code;
  logic [IW-1:0]        w_ptr_nxt;
  logic                 w_wdog_exp;

  kiwi_rr_arbiter #(.N(N_THREADS), .IW(IW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_vld   (w_vld)
  );

  always_comb begin
    w_code = '0;
    for (int k = 0; k < N_THREADS; k++) begin
      if (w_idx == IW'(k)) w_code = req_code[8*k +: 8];
    end
  end

  assign w_ptr_nxt  = (w_idx == IW'(N_THREADS - 1)) ? '0 : w_idx + 1'b1;
  assign w_wdog_exp = (WDOG_LIMIT != 0) && (r_wdog == 32'(WDOG_LIMIT - 1));
  assign req_ready  = (r_state == RUN) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_wdog  <= '0;
      r_syn   <= ABEND_IDLE;
      r_win   <= '0;
      r_cnt   <= '0;
      r_fin   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= RUN;
          r_syn   <= ABEND_RUNNING;
        end
        RUN: begin
          if (r_cnt != 32'hFFFF_FFFF) r_cnt <= r_cnt + 32'd1;
          // A transfer on the expiry cycle pre-empts the watchdog.
          if (w_vld) begin
            r_wdog <= '0;
            r_ptr  <= w_ptr_nxt;
            if (is_terminal(w_code)) begin
              r_state <= DONE;
              r_syn   <= w_code;
              r_win   <= WW'(w_idx);
              r_fin   <= 1'b1;
            end
          end else if (w_wdog_exp) begin
            r_state <= DONE;
            r_syn   <= WDOG_CODE;
            r_win   <= WW'(N_THREADS);
            r_fin   <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ksubsAbendSyndrome = r_syn;
  assign finished           = r_fin;
  assign winner_id          = r_win;
  assign cycle_count        = r_cnt;

endmodule

// File: tb/tb_kiwi_abend_arbiter.sv
// Bench for kiwi_abend_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_kiwi_abend_arbiter;

  localparam int          N   = 4;
  localparam int unsigned LIM = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_code = '0;
  logic [N-1:0]     req_ready;
  logic [7:0]       syn;
  logic             finished;
  logic [2:0]       winner_id;
  logic [31:0]      cycle_count;

  int tests = 0;
  int fails = 0;

  kiwi_abend_arbiter #(.N_THREADS(N), .WDOG_LIMIT(LIM), .WDOG_CODE(8'hFE)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_code           (req_code),
    .req_ready          (req_ready),
    .ksubsAbendSyndrome (syn),
    .finished           (finished),
    .winner_id          (winner_id),
    .cycle_count        (cycle_count)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = waiting after reset, 1 = running, 2 = ended.
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_quiet = 0;
  logic [7:0]  m_syn   = 8'h00;
  int          m_win   = 0;
  logic [31:0] m_cnt   = 0;
  int          mg;
  logic [7:0]  mc;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = pick(req_valid, m_ptr);
    if (m_phase != 1 || g < 0) return '0;
    return N'(1) << g;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_quiet = 0; m_syn = 8'h00; m_win = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_syn = 8'h80;
    end else if (m_phase == 1) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      mg = pick(req_valid, m_ptr);
      if (mg >= 0) begin
        m_quiet = 0;
        m_ptr   = (mg + 1) % N;
        mc      = req_code[8*mg +: 8];
        if (mc != 8'h00 && mc != 8'h80) begin
          m_phase = 2; m_syn = mc; m_win = mg;
        end
      end else if (LIM != 0 && m_quiet + 1 >= int'(LIM)) begin
        m_phase = 2; m_syn = 8'hFE; m_win = N;
      end else begin
        m_quiet = m_quiet + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    chk("syndrome",    syn,         m_syn);
    chk("finished",    finished,    {31'd0, (m_syn != 8'h00 && m_syn != 8'h80)});
    chk("winner_id",   winner_id,   m_win);
    chk("cycle_count", cycle_count, m_cnt);
    chk("req_ready",   req_ready,   exp_ready());
  end

  task automatic cyc(input logic rst, input logic [N-1:0] v, input logic [8*N-1:0] c);
    @(negedge clk);
    reset = rst; req_valid = v; req_code = c;
    #3;
  endtask

  // Leaves the DUT in its last IDLE cycle with reset low; the next cyc is RUN cycle 1.
  task automatic start_run();
    cyc(1'b1, '0, '0);
    cyc(1'b1, '0, '0);
    cyc(1'b0, '0, '0);
  endtask

  localparam logic [8*N-1:0] HB     = {4{8'h80}};
  localparam logic [8*N-1:0] TCODES = {8'h00, 8'h01, 8'h00, 8'h80};
  localparam logic [8*N-1:0] C33    = {8'h80, 8'h80, 8'h33, 8'h80};
  logic [N-1:0] rr_exp [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

  logic [N-1:0]   rv;
  logic [8*N-1:0] rc;
  int             dens;
  int             rsel;

  initial begin
    for (int i = 0; i < 4; i++) cyc(1'b1, '0, '0);
    chk("lit_rst_syn", syn, 32'h00);
    chk("lit_rst_fin", finished, 32'd0);
    cyc(1'b0, '0, '0);

    // Thread 0 heartbeat at RUN cycle 5, thread 2 terminal 0x01 at RUN cycle 10.
    for (int r = 1; r <= 10; r++) begin
      cyc(1'b0, (r == 5) ? 4'b0001 : ((r == 10) ? 4'b0100 : 4'b0000), TCODES);
      if (r == 1) chk("lit_run1_syn", syn, 32'h80);
      if (r == 2) chk("lit_run2_cnt", cycle_count, 32'd1);
    end
    cyc(1'b0, 4'hF, TCODES);
    chk("lit_term_syn", syn, 32'h01);
    chk("lit_term_fin", finished, 32'd1);
    chk("lit_term_win", winner_id, 32'd2);
    chk("lit_term_cnt", cycle_count, 32'd10);
    chk("lit_done_rdy", req_ready, 32'd0);
    cyc(1'b0, 4'hF, TCODES);
    chk("lit_done_cnt", cycle_count, 32'd10);

    // Reset while DONE.
    cyc(1'b1, 4'hF, TCODES);
    cyc(1'b0, '0, '0);
    chk("lit_rst2_syn", syn, 32'h00);
    chk("lit_rst2_fin", finished, 32'd0);
    chk("lit_rst2_cnt", cycle_count, 32'd0);

    // Round robin with every thread heartbeating.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'hF, HB);
      chk("lit_rr_grant", req_ready, rr_exp[i]);
      chk("lit_rr_syn", syn, 32'h80);
    end

    // Watchdog from RUN entry.
    start_run();
    for (int r = 1; r <= 8; r++) cyc(1'b0, '0, '0);
    chk("lit_wd_pre", syn, 32'h80);
    cyc(1'b0, '0, '0);
    chk("lit_wd_syn", syn, 32'hFE);
    chk("lit_wd_win", winner_id, 32'd4);
    chk("lit_wd_cnt", cycle_count, 32'd8);

    // Watchdog restarted by a heartbeat at RUN cycle 5.
    start_run();
    for (int r = 1; r <= 13; r++) begin
      cyc(1'b0, (r == 5) ? 4'b1000 : 4'b0000, HB);
      if (r == 8)  chk("lit_wd2_mid", syn, 32'h80);
      if (r == 13) chk("lit_wd2_pre", syn, 32'h80);
    end
    cyc(1'b0, '0, '0);
    chk("lit_wd2_syn", syn, 32'hFE);
    chk("lit_wd2_cnt", cycle_count, 32'd13);

    // Terminal transfer on the expiry cycle beats the watchdog.
    start_run();
    for (int r = 1; r <= 8; r++) cyc(1'b0, (r == 8) ? 4'b0010 : 4'b0000, C33);
    cyc(1'b0, '0, '0);
    chk("lit_race_syn", syn, 32'h33);
    chk("lit_race_win", winner_id, 32'd1);
    chk("lit_race_cnt", cycle_count, 32'd8);

    // Reset in RUN overrides a terminal transfer in the same cycle.
    start_run();
    cyc(1'b0, '0, '0);
    cyc(1'b1, 4'b0100, TCODES);
    cyc(1'b0, '0, '0);
    chk("lit_rstrun_syn", syn, 32'h00);

    // Random traffic with varying request density.
    dens = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) dens = $urandom_range(0, 4);
      for (int t = 0; t < N; t++) begin
        rv[t] = ($urandom_range(0, 7) < dens);
        rsel  = $urandom_range(0, 99);
        rc[8*t +: 8] = (rsel < 4) ? 8'($urandom) : ((rsel < 52) ? 8'h80 : 8'h00);
      end
      cyc($urandom_range(0, 40) == 0, rv, rc);
    end
    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
